// File: rtl/data_mem_unit.sv
// data_mem_unit: byte-addressable little-endian data memory for the MEM stage.
// Supports 32-bit word and 8-bit byte loads/stores with one-cycle registered
// read data. Word accesses wrap at the top of the decoded address space and
// misaligned word accesses are serviced as-is.
// Optional feature macro: BYTE_LOAD_SIGN_EXT_EN (byte loads sign-extend
// instead of zero-extend when defined).
module data_mem_unit #(
  parameter int ADDR_BITS = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  input  logic [1:0]  mem_write_read,
  input  logic        word_byte,
  output logic [31:0] read_data
);

  localparam int DEPTH = 1 << ADDR_BITS;

  localparam logic [1:0] CMD_WRITE = 2'b01;
  localparam logic [1:0] CMD_READ  = 2'b10;

  // Power-up contents are zero; reset never touches the array.
  logic [7:0] mem [DEPTH] = '{default: 8'h00};

  logic [ADDR_BITS-1:0] addr0;
  logic [ADDR_BITS-1:0] addr1;
  logic [ADDR_BITS-1:0] addr2;
  logic [ADDR_BITS-1:0] addr3;
  logic [31:0]          word_value;
  logic [7:0]           byte_value;
  logic [31:0]          byte_extended;
  logic                 do_write;
  logic                 do_read;
  logic                 unused_upper_address;

  // Only the low address bits are decoded; the rest alias onto the same bytes.
  assign unused_upper_address = ^address[31:ADDR_BITS];

  // Byte lanes of a word access; the add truncates so accesses wrap at the top.
  assign addr0 = address[ADDR_BITS-1:0];
  assign addr1 = addr0 + ADDR_BITS'(1);
  assign addr2 = addr0 + ADDR_BITS'(2);
  assign addr3 = addr0 + ADDR_BITS'(3);

  assign do_write = rst_n && (mem_write_read == CMD_WRITE);
  assign do_read  = mem_write_read == CMD_READ;

  assign word_value = {mem[addr3], mem[addr2], mem[addr1], mem[addr0]};
  assign byte_value = mem[addr0];

`ifdef BYTE_LOAD_SIGN_EXT_EN
  assign byte_extended = {{24{byte_value[7]}}, byte_value};
`else
  assign byte_extended = {24'h000000, byte_value};
`endif

  // Store path: a word store updates four consecutive bytes in one edge,
  // a byte store updates only the addressed byte; reset suppresses stores.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[addr0] <= write_data[7:0];
      if (word_byte) begin
        mem[addr1] <= write_data[15:8];
        mem[addr2] <= write_data[23:16];
        mem[addr3] <= write_data[31:24];
      end
    end
  end

  // Load path: registered result that holds on stores and no-ops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      read_data <= 32'h00000000;
    end else if (do_read) begin
      read_data <= word_byte ? word_value : byte_extended;
    end
  end

endmodule

// File: tb/tb_data_mem_unit.sv
// tb_data_mem_unit: scoreboard bench for data_mem_unit. The driver applies a
// directed sequence followed by random commands, and for every clock edge
// pushes the expected read_data into a queue; a separate monitor pops and
// compares just after each rising edge.
module tb_data_mem_unit;

  localparam int ADDR_BITS = 10;
  localparam int DEPTH     = 1024;

  logic        clk;
  logic        rst_n;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [1:0]  mem_write_read;
  logic        word_byte;
  logic [31:0] read_data;

  int checks;
  int errors;

  logic [31:0] exp_q[$];
  string       name_q[$];

  logic [7:0]  model_mem [DEPTH];
  logic [31:0] model_rd;

  data_mem_unit #(.ADDR_BITS(ADDR_BITS)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .address        (address),
    .write_data     (write_data),
    .mem_write_read (mem_write_read),
    .word_byte      (word_byte),
    .read_data      (read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one edge of behaviour, computed from the memory rules.
  task automatic model_step(input logic rst, input logic [1:0] cmd,
                            input logic wb, input logic [31:0] addr,
                            input logic [31:0] wd);
    int a;
    a = int'(addr % DEPTH);
    if (!rst) begin
      model_rd = 0;
    end else if (cmd == 2'b01) begin
      if (wb) begin
        for (int i = 0; i < 4; i++)
          model_mem[(a + i) % DEPTH] = 8'((wd >> (8 * i)) & 32'hFF);
      end else begin
        model_mem[a] = 8'(wd & 32'hFF);
      end
    end else if (cmd == 2'b10) begin
      if (wb) begin
        model_rd = 0;
        for (int i = 0; i < 4; i++)
          model_rd = model_rd + (32'(model_mem[(a + i) % DEPTH]) << (8 * i));
      end else begin
        model_rd = 32'(model_mem[a]);
`ifdef BYTE_LOAD_SIGN_EXT_EN
        if (model_rd >= 128) model_rd = model_rd | 32'hFFFFFF00;
`endif
      end
    end
  endtask

  // Drive one command for one edge and push the expected result. A directed
  // step may supply a hand-derived expected value instead of the model's.
  task automatic issue(input logic rst, input logic [1:0] cmd, input logic wb,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic use_const, input logic [31:0] const_val,
                       input string name);
    @(negedge clk);
    rst_n          = rst;
    mem_write_read = cmd;
    word_byte      = wb;
    address        = addr;
    write_data     = wd;
    model_step(rst, cmd, wb, addr, wd);
    exp_q.push_back(use_const ? const_val : model_rd);
    name_q.push_back(name);
  endtask

  // Monitor: after every rising edge, compare the next expected value.
  initial begin
    logic [31:0] exp_val;
    string       exp_name;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_val  = exp_q.pop_front();
        exp_name = name_q.pop_front();
        checks++;
        if (read_data !== exp_val) begin
          errors++;
          $display("[TB] FAIL %s: read_data=0x%08h expected=0x%08h at %0t",
                   exp_name, read_data, exp_val, $time);
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  // Stimulus: directed plan, then randomized traffic.
  initial begin
    logic [31:0] byte5_exp;
    logic [31:0] r_addr;
    logic [1:0]  r_cmd;
    logic        r_rst;
    int          wait_cycles;

    checks = 0;
    errors = 0;
    model_rd = 0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;
    rst_n = 1'b0;
    mem_write_read = 2'b00;
    word_byte = 1'b1;
    address = 0;
    write_data = 0;

`ifdef BYTE_LOAD_SIGN_EXT_EN
    byte5_exp = 32'hFFFFFF80;
`else
    byte5_exp = 32'h00000080;
`endif

    issue(1'b0, 2'b10, 1'b1, 32'd0, 32'd0, 1'b1, 32'h0, "reset");
    issue(1'b1, 2'b10, 1'b1, 32'd0, 32'd0, 1'b1, 32'h0, "powerup_word_read_0");
    issue(1'b1, 2'b01, 1'b1, 32'd4, 32'd100, 1'b1, 32'h0, "hold_during_write");
    issue(1'b1, 2'b10, 1'b1, 32'd4, 32'd0, 1'b1, 32'h00000064, "word_read_4");
    issue(1'b1, 2'b10, 1'b0, 32'd4, 32'd0, 1'b1, 32'h00000064, "byte_read_4");
    issue(1'b1, 2'b10, 1'b1, 32'd3, 32'd0, 1'b1, 32'h00006400, "misaligned_read_3");
    issue(1'b1, 2'b01, 1'b0, 32'd5, 32'hABCDEF80, 1'b1, 32'h00006400, "hold_byte_write");
    issue(1'b1, 2'b10, 1'b1, 32'd4, 32'd0, 1'b1, 32'h00008064, "word_read_4_after_byte");
    issue(1'b1, 2'b10, 1'b0, 32'd5, 32'd0, 1'b1, byte5_exp, "byte_read_5_ext");
    issue(1'b1, 2'b01, 1'b1, 32'd1022, 32'h11223344, 1'b1, byte5_exp, "wrap_write_hold");
    issue(1'b1, 2'b10, 1'b1, 32'd1022, 32'd0, 1'b1, 32'h11223344, "wrap_word_read");
    issue(1'b1, 2'b10, 1'b0, 32'd0, 32'd0, 1'b1, 32'h00000022, "wrap_byte_read_0");
    issue(1'b1, 2'b10, 1'b0, 32'd1, 32'd0, 1'b1, 32'h00000011, "wrap_byte_read_1");
    issue(1'b1, 2'b10, 1'b1, 32'h00000404, 32'd0, 1'b1, 32'h00008064, "alias_read_404");
    issue(1'b1, 2'b11, 1'b1, 32'd4, 32'hFFFFFFFF, 1'b1, 32'h00008064, "noop_11_hold");
    issue(1'b1, 2'b00, 1'b1, 32'd4, 32'hFFFFFFFF, 1'b1, 32'h00008064, "noop_00_hold");
    issue(1'b1, 2'b10, 1'b1, 32'd4, 32'd0, 1'b1, 32'h00008064, "noop_mem_unchanged");
    issue(1'b0, 2'b01, 1'b1, 32'd8, 32'hDEADBEEF, 1'b1, 32'h0, "reset_mid_write");
    issue(1'b1, 2'b10, 1'b1, 32'd8, 32'd0, 1'b1, 32'h0, "reset_blocked_write");

    for (int n = 0; n < 2000; n++) begin
      case ($urandom_range(0, 2))
        0: r_addr = 32'($urandom_range(0, 15));
        1: r_addr = 32'($urandom_range(DEPTH - 6, DEPTH - 1));
        default: r_addr = 32'($urandom_range(0, DEPTH - 1));
      endcase
      r_addr = r_addr | ($urandom() & 32'hFFFFFC00);
      r_cmd  = 2'($urandom_range(0, 3));
      r_rst  = ($urandom_range(0, 31) != 0);
      issue(r_rst, r_cmd, 1'($urandom_range(0, 1)), r_addr, $urandom(),
            1'b0, 32'h0, "random");
    end

    @(negedge clk);
    rst_n = 1'b1;
    mem_write_read = 2'b00;
    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(negedge clk);
      wait_cycles++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: pending=%0d expected=0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
